// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the countdown_timer slice.
//   - timer FSM state encoding
//   - register window indices (bridge addr[3:2])
//   - CTRL bit positions and mode values
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_e;

  // Register window, word index within the device.
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  // CTRL layout; only these four bits are stored.
  localparam int CTRL_W        = 4;
  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;

  // Modes 2 and 3 are treated as one-shot.
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

endpackage

// File: rtl/countdown_timer.sv
// countdown_timer: memory-mapped programmable countdown timer.
//   Mode 0 (one-shot): interrupt held until a CTRL or PRESET write acknowledges it.
//   Mode 1 (auto-reload): one-cycle interrupt pulse every PRESET+2 cycles.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high
//   addr   in   [1:0] word select: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved
//   we     in   write strobe (device already selected by the bridge)
//   wdata  in   [WIDTH-1:0] write data
//   rdata  out  [WIDTH-1:0] combinational read of the selected register
//   irq    out  interrupt request (pending & IM)
module countdown_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq
);

  timer_state_e      state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [WIDTH-1:0]  preset_q, preset_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic              pending_q, pending_d;

  logic       ctrl_wr;
  logic       preset_wr;
  logic       en;
  logic [1:0] mode;

  assign ctrl_wr   = we && (addr == REG_CTRL);
  assign preset_wr = we && (addr == REG_PRESET);
  assign en        = ctrl_q[CTRL_EN];
  assign mode      = ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB];

  // NOTE: combinational blocks use blocking '=' with every output defaulted
  // first, so later statements can override earlier ones and no latch is inferred.
  always_comb begin
    logic fired;
    logic reload_exit;
    logic clear_en;

    state_d     = state_q;
    ctrl_d      = ctrl_q;
    preset_d    = preset_q;
    count_d     = count_q;
    pending_d   = pending_q;
    fired       = 1'b0;
    reload_exit = 1'b0;
    clear_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;               // COUNT frozen
        end else if (count_q > WIDTH'(1)) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          // PRESET=0 lands here too, so it behaves like PRESET=1.
          count_d = '0;
          fired   = 1'b1;
          state_d = ST_INT;
        end
      end
      ST_INT: begin
        if (mode == MODE_RELOAD) begin
          reload_exit = 1'b1;
          state_d     = ST_LOAD;
        end else begin
          clear_en = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pending: an expiry this cycle beats an acknowledge on the same edge,
    // so an interrupt is never silently dropped.
    if (reload_exit)           pending_d = 1'b0;
    if (ctrl_wr || preset_wr)  pending_d = 1'b0;
    if (fired)                 pending_d = 1'b1;

    // A CPU write to CTRL overrides the FSM's one-shot En clear.
    if (clear_en) ctrl_d[CTRL_EN] = 1'b0;
    if (ctrl_wr)  ctrl_d = wdata[CTRL_W-1:0];

    if (preset_wr) preset_d = wdata;
  end

  // NOTE: flops use non-blocking '<='; the reset is synchronous, so it is
  // sampled only on the clock edge like any other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      preset_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (addr)
      REG_CTRL:   rdata = {{(WIDTH-CTRL_W){1'b0}}, ctrl_q};
      REG_PRESET: rdata = preset_q;
      REG_COUNT:  rdata = count_q;
      default:    rdata = '0;
    endcase
  end

  assign irq = pending_q & ctrl_q[CTRL_IM];

endmodule
